// File: rtl/sz_seq_pkg.sv
// Shared types and constants for the sz_inner sequencer.
package sz_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStream,
        StDrain,
        StFlush,
        StDone
    } seq_state_e;

    localparam int unsigned CODE_W            = 2;
    localparam int unsigned CODES_PER_BYTE    = 4;
    localparam int unsigned DRAIN_CYC_DEFAULT = 45;

    // Drop a code into its slot; slot 0 is the most significant pair.
    function automatic logic [7:0] place_code(input logic [7:0]        acc,
                                              input logic [CODE_W-1:0] code,
                                              input logic [1:0]        slot);
        logic [7:0] shifted;
        shifted = {code, 6'b000000} >> {slot, 1'b0};
        return acc | shifted;
    endfunction

endpackage

// File: rtl/sz_inner_seq_packer.sv
// Packs 2-bit encode codes into bytes, first code in [7:6]; flush emits a
// partial byte with the unused low slots zero.
module sz_code_packer
    import sz_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              flush,
    output logic [7:0]        code_byte,
    output logic              code_byte_valid,
    output logic [1:0]        occupancy
);

    logic [7:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic       emit;
    logic [7:0] emit_byte;
    logic [7:0] acc_with;

    // Next accumulator/slot and whether a byte leaves this cycle.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_byte = 8'h00;
        acc_with  = place_code(acc_q, code, cnt_q);
        if (code_valid) begin
            if (cnt_q == 2'(CODES_PER_BYTE - 1)) begin
                emit      = 1'b1;
                emit_byte = acc_with;
                acc_d     = 8'h00;
                cnt_d     = 2'd0;
            end else begin
                acc_d = acc_with;
                cnt_d = cnt_q + 2'd1;
            end
        end
        // A just-completed byte already cleared the slots, so no double emit.
        if (flush && cnt_d != 2'd0) begin
            emit      = 1'b1;
            emit_byte = acc_d;
            acc_d     = 8'h00;
            cnt_d     = 2'd0;
        end
    end

    // Register the accumulator and the outgoing byte strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= 8'h00;
            cnt_q           <= 2'd0;
            code_byte       <= 8'h00;
            code_byte_valid <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            code_byte_valid <= emit;
            if (emit) begin
                code_byte <= emit_byte;
            end
        end
    end

    assign occupancy = cnt_q;

endmodule

// File: rtl/sz_inner_seq.sv
// Sequencer around the sz_inner core: forwards a block of samples, keeps the
// core alive for a drain window, packs encode codes into bytes.
// Optional stats outputs are built when SZ_SEQ_STATS_EN is defined.
module sz_inner_seq
    import sz_seq_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 20,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  block_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] sz_data_in,
    output logic              sz_enable,
    output logic              sz_hold,
    input  logic [1:0]        sz_code,
    input  logic              sz_code_valid,
    output logic [7:0]        code_byte,
    output logic              code_byte_valid,
    output logic              busy,
    output logic              done,
    output logic              err_late
`ifdef SZ_SEQ_STATS_EN
    ,
    output logic [LEN_W-1:0]  stat_beats,
    output logic [LEN_W-1:0]  stat_bytes
`endif
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

    seq_state_e       state_q;
    logic [LEN_W-1:0] block_len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [7:0]       drain_cnt_q;
    logic             beat;
    logic             code_window;
    logic             pack_valid;
    logic             drain_last;
    logic             pack_flush;
    logic [1:0]       pack_occ;

    // Handshake and window decode from the current state.
    always_comb begin
        in_ready    = (state_q == StStream);
        busy        = (state_q != StIdle);
        beat        = in_valid && in_ready;
        code_window = (state_q == StStream) || (state_q == StDrain);
        pack_valid  = sz_code_valid && code_window;
        // The drain window only counts once the last sz_enable has gone low.
        drain_last  = (state_q == StDrain) && !sz_enable && (drain_cnt_q == DRAIN_LAST);
        pack_flush  = drain_last && ((pack_occ != 2'd0) || pack_valid);
    end

    // Block FSM with registered core-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            block_len_q <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= 8'd0;
            sz_data_in  <= '0;
            sz_enable   <= 1'b0;
            sz_hold     <= 1'b0;
            done        <= 1'b0;
            err_late    <= 1'b0;
        end else begin
            sz_enable <= 1'b0;
            done      <= 1'b0;
            if (sz_code_valid && !code_window) begin
                err_late <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        block_len_q <= block_len;
                        beat_cnt_q  <= '0;
                        drain_cnt_q <= 8'd0;
                        sz_hold     <= 1'b1;
                        state_q     <= (block_len == '0) ? StDrain : StStream;
                    end
                end
                StStream: begin
                    if (beat) begin
                        sz_data_in <= in_data;
                        sz_enable  <= 1'b1;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == block_len_q - 1'b1) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_last) begin
                        sz_hold <= 1'b0;
                        state_q <= StFlush;
                    end else if (!sz_enable) begin
                        drain_cnt_q <= drain_cnt_q + 8'd1;
                    end
                end
                StFlush: begin
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sz_code_packer u_packer (
        .clk             (clk),
        .rst             (rst),
        .code            (sz_code),
        .code_valid      (pack_valid),
        .flush           (pack_flush),
        .code_byte       (code_byte),
        .code_byte_valid (code_byte_valid),
        .occupancy       (pack_occ)
    );

`ifdef SZ_SEQ_STATS_EN
    // Per-block beat and byte counts, frozen from DONE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats <= '0;
            stat_bytes <= '0;
        end else if (state_q == StIdle) begin
            if (start) begin
                stat_beats <= '0;
                stat_bytes <= '0;
            end
        end else if (state_q != StDone) begin
            if (beat) begin
                stat_beats <= stat_beats + 1'b1;
            end
            if (code_byte_valid) begin
                stat_bytes <= stat_bytes + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sz_inner_seq.sv
// Scoreboard bench for sz_inner_seq: stimulus pushes expected samples, bytes
// and block tokens; a negedge monitor pops and compares.
module tb_sz_inner_seq;

    localparam int DRAIN     = 45;
    localparam int DONE_GAP  = DRAIN + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] block_len;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sz_data_in;
    logic        sz_enable;
    logic        sz_hold;
    logic [1:0]  sz_code;
    logic        sz_code_valid;
    logic [7:0]  code_byte;
    logic        code_byte_valid;
    logic        busy;
    logic        done;
    logic        err_late;
`ifdef SZ_SEQ_STATS_EN
    logic [19:0] stat_beats;
    logic [19:0] stat_bytes;
`endif

    sz_inner_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .block_len       (block_len),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sz_data_in      (sz_data_in),
        .sz_enable       (sz_enable),
        .sz_hold         (sz_hold),
        .sz_code         (sz_code),
        .sz_code_valid   (sz_code_valid),
        .code_byte       (code_byte),
        .code_byte_valid (code_byte_valid),
        .busy            (busy),
        .done            (done),
        .err_late        (err_late)
`ifdef SZ_SEQ_STATS_EN
        ,
        .stat_beats      (stat_beats),
        .stat_bytes      (stat_bytes)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_data_q[$];
    logic [7:0]  exp_byte_q[$];
    int          exp_done_q[$];   // expected beat count per block

    int cyc       = 0;
    int ref_cyc   = 0;
    int hold_run  = 0;
    int en_cnt    = 0;
    int done_seen = 0;
    bit prev_beat = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_beat = 1'b0;
            hold_run  = 0;
            en_cnt    = 0;
        end else begin
            if (sz_enable || prev_beat) begin
                check("enable_latency", 32'(sz_enable), 32'(prev_beat));
            end
            if (sz_enable) begin
                en_cnt++;
                ref_cyc  = cyc;
                hold_run = 0;
                if (exp_data_q.size() == 0) begin
                    check("unexpected_sz_enable", 32'(sz_data_in), 32'hx);
                end else begin
                    check("sz_data_in", sz_data_in, exp_data_q.pop_front());
                end
            end else if (sz_hold) begin
                hold_run++;
            end
            if (code_byte_valid) begin
                if (exp_byte_q.size() == 0) begin
                    check("unexpected_byte", 32'(code_byte), 32'hx);
                end else begin
                    check("code_byte", 32'(code_byte), 32'(exp_byte_q.pop_front()));
                end
            end
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    check("block_beats", 32'(en_cnt), 32'(exp_done_q.pop_front()));
                    check("done_gap", 32'(cyc - ref_cyc), 32'(DONE_GAP));
                    check("hold_after_enable", 32'(hold_run), 32'(DRAIN));
                end
            end
            if (!busy) begin
                hold_run = 0;
                if (start) begin
                    ref_cyc = cyc;
                    en_cnt  = 0;
                end
            end
            prev_beat = in_valid && in_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        block_len = 20'(len);
        exp_done_q.push_back(len);
        tick();
        start     = 1'b0;
        block_len = 20'd7;  // later changes must not matter
    endtask

    // Drive ncyc cycles of samples; the first len offered are the accepted beats.
    task automatic drive_beats(input int len, input int ncyc, input bit toggle,
                               input logic [31:0] base,
                               input logic [1:0] codes [8], input int ncodes);
        int sent = 0;
        for (int i = 0; i < ncyc; i++) begin
            in_valid      = toggle ? (i % 2 == 0) : 1'b1;
            in_data       = base + 32'(i);
            sz_code_valid = (i < ncodes);
            sz_code       = (i < ncodes) ? codes[i] : 2'd0;
            if (in_valid && sent < len) begin
                exp_data_q.push_back(in_data);
                sent++;
            end
            tick();
        end
        in_valid      = 1'b0;
        sz_code_valid = 1'b0;
    endtask

    task automatic wait_done();
        int seen0 = done_seen;
        for (int k = 0; k < 200 && done_seen == seen0; k++) begin
            tick();
        end
        check("done_arrived", 32'(done_seen != seen0), 32'h1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        check({tag, "_sz_enable"}, 32'(sz_enable), 32'h0);
        check({tag, "_sz_hold"}, 32'(sz_hold), 32'h0);
        check({tag, "_sz_data_in"}, sz_data_in, 32'h0);
        check({tag, "_code_byte"}, 32'(code_byte), 32'h0);
        check({tag, "_code_byte_valid"}, 32'(code_byte_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_err_late"}, 32'(err_late), 32'h0);
    endtask

    logic [1:0] codes_a [8];
    logic [1:0] codes_b [8];
    logic [1:0] codes_c [8];
    logic [1:0] no_codes [8];

    initial begin
        codes_a  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        codes_b  = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        codes_c  = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        no_codes = '{default: 2'd0};

        rst = 1'b1; start = 1'b0; block_len = '0; in_data = '0; in_valid = 1'b0;
        sz_code = 2'd0; sz_code_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Code in IDLE: dropped, err_late set and sticky.
        sz_code_valid = 1'b1; sz_code = 2'd2;
        tick();
        sz_code_valid = 1'b0;
        tick();
        check("err_late_set", 32'(err_late), 32'h1);

        // block_len=8, constant valid, codes 0..3,3..0 -> 0x1B, 0xE4.
        exp_byte_q.push_back(8'h1B);
        exp_byte_q.push_back(8'hE4);
        do_start(8);
        drive_beats(8, 8, 1'b0, 32'h1000_0000, codes_a, 8);
        wait_done();
        check("err_late_sticky", 32'(err_late), 32'h1);

        // block_len=5, valid toggling; extra offers after the 5th are refused.
        do_start(5);
        start = 1'b1;  // ignored while busy
        drive_beats(5, 11, 1'b1, 32'hA5A5_0000, no_codes, 0);
        start = 1'b0;
        check("in_ready_after_last", 32'(in_ready), 32'h0);
        wait_done();

        // Three codes then flush -> padded 0xFC.
        exp_byte_q.push_back(8'hFC);
        do_start(3);
        drive_beats(3, 3, 1'b0, 32'h0000_3000, codes_b, 3);
        wait_done();

        // block_len=0: no enables, hold 45 cycles, no byte, done pulses.
        do_start(0);
        wait_done();

        // Reset at drain_cnt=10 aborts the block with no done.
        do_start(2);
        drive_beats(2, 2, 1'b0, 32'h0000_5000, no_codes, 0);
        for (int k = 0; k < 11; k++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_done_q.delete();
        check_reset_outputs("abort");
        for (int k = 0; k < 60; k++) begin
            tick();
        end

        // Fresh block after abort runs normally; single code pads to 0x40.
        exp_byte_q.push_back(8'h40);
        do_start(1);
        drive_beats(1, 1, 1'b0, 32'h0000_6000, codes_c, 1);
        wait_done();

        check("pending_samples", 32'(exp_data_q.size()), 32'h0);
        check("pending_bytes", 32'(exp_byte_q.size()), 32'h0);
        check("pending_blocks", 32'(exp_done_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sz_inner_seq.md
Name: sz_inner_seq

Overview:
- Sequencer in front of and behind the sz_inner compression core.
- Accepts a block of 32-bit samples over a valid/ready handshake and forwards them to the core with sz_enable.
- Holds the core pipeline alive for a fixed drain window after the last sample, then releases sz_hold.
- Packs the core's 2-bit encode stream into bytes and signals block completion.

Parameters:
- DATA_W, 32, sample width to the core.
- LEN_W, 20, width of block_len and the beat counter.
- DRAIN_CYC, 45, cycles sz_hold stays high after the last forwarded sample. Legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin block; sampled only in IDLE.
- block_len  in  LEN_W  samples in block; captured on an accepted start.
- in_data  in  DATA_W  sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  sequencer can accept a sample.
- sz_data_in  out  DATA_W  sample to core.
- sz_enable  out  1  advance core fitting window.
- sz_hold  out  1  keep core pipeline running / outputs live.
- sz_code  in  2  core encode output.
- sz_code_valid  in  1  encode output valid.
- code_byte  out  8  packed codes; first code in [7:6].
- code_byte_valid  out  1  one-cycle strobe per byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at block end.
- err_late  out  1  sticky: code arrived outside STREAM/DRAIN.

Behaviour:
- Reset (sync, active-high): state=IDLE; clears all counters and the packer.
- Reset values of outputs: in_ready=0, sz_enable=0, sz_hold=0, sz_data_in=0, code_byte=0, code_byte_valid=0, busy=0, done=0, err_late=0.
- Reset mid-block aborts with no done and no flush byte.
- IDLE: on start, capture block_len and set sz_hold=1.
  - block_len==0: next state DRAIN.
  - Otherwise: next state STREAM.
- STREAM: in_ready=1 combinationally.
  - Beat = in_valid && in_ready.
  - A beat registers sz_data_in<=in_data and sz_enable<=1 (1-cycle latency). sz_enable=0 on cycles with no beat; sz_data_in holds its last value.
  - beat_cnt increments per beat.
  - On the beat where beat_cnt==block_len-1: in_ready drops the next cycle and the next state is DRAIN.
- DRAIN: in_ready=0, sz_enable=0, sz_hold=1.
  - drain_cnt counts 0..DRAIN_CYC-1, then the next state is FLUSH.
  - sz_hold therefore stays high exactly DRAIN_CYC cycles after the last sz_enable.
- FLUSH (1 cycle): sz_hold=0.
  - If the packer holds 1..3 codes, emit the byte with unused low slots zero-padded (code_byte_valid=1).
  - If the packer holds 0 codes, nothing is emitted.
  - Next state DONE.
- DONE (1 cycle): done=1; next state IDLE.
- Packer, active in STREAM and DRAIN:
  - Each sz_code_valid shifts the code into the next slot: [7:6], [5:4], [3:2], [1:0].
  - The 4th code produces code_byte_valid the next cycle; the slot index wraps to 0.
- sz_code_valid in IDLE/FLUSH/DONE: code dropped, err_late<=1. err_late is cleared only by rst.
- start while busy is ignored. block_len changes after capture have no effect.

Optional Feature:
- Macro SZ_SEQ_STATS_EN.
- Defined: adds outputs stat_beats[LEN_W-1:0] and stat_bytes[LEN_W-1:0].
  - They count beats and emitted bytes (including the pad byte) for the current block.
  - Cleared on an accepted start; frozen from DONE until the next start; reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package sz_seq_pkg:
  - state enum {IDLE, STREAM, DRAIN, FLUSH, DONE}.
  - CODE_W=2, CODES_PER_BYTE=4, DRAIN_CYC_DEFAULT=45.
- Sub-module sz_code_packer: 2-bit to 8-bit packer.
  - Interfaces: code/valid in, flush in, byte/valid out, occupancy out.
- Top level holds the FSM, counters and handshake.

Test Plan:
- block_len=8, in_valid constant, codes 0,1,2,3,3,2,1,0 during STREAM -> 8 sz_enable pulses, each 1 cycle after its beat; bytes 0x1B then 0xE4; sz_hold high through the 45th drain cycle; done 47 cycles after the last sz_enable.
- block_len=5, in_valid toggling 1010… -> exactly 5 beats, in_ready low after the 5th; sz_data_in matches in_data order.
- Codes 3,3,3 then drain ends -> FLUSH emits 0xFC; stat_bytes=1 with SZ_SEQ_STATS_EN.
- block_len=0 -> no sz_enable; sz_hold high 45 cycles; no byte; done pulses.
- rst asserted in DRAIN at drain_cnt=10 -> next cycle all outputs at reset values, no done; a new start then runs normally.
- sz_code_valid asserted in IDLE -> err_late=1 and stays 1 across a full block until rst.
